// File: rtl/ravan_sha_block_sequencer_if.sv
// Register-bus bundle between the block sequencer (master)
// and the SHA-256 core (slave).
interface ravan_sha_block_sequencer_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
);
   logic              cs;
   logic              we;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] write_data;
   logic [DATA_W-1:0] read_data;
   logic              core_error;

   modport master (
      output cs, we, address, write_data,
      input  read_data, core_error
   );

   modport slave (
      input  cs, we, address, write_data,
      output read_data, core_error
   );
endinterface

// File: rtl/ravan_sha_block_sequencer.sv
// Host-side sequencer: loads a message block into the SHA-256 core,
// commands init/next, polls status and reads back the digest.
module ravan_sha_block_sequencer #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 8,
   parameter int NUM_WORDS    = 16,
   parameter int DIGEST_WORDS = 8,
   parameter int CTRL_ADDR    = 'h08,
   parameter int STATUS_ADDR  = 'h09,
   parameter int BLOCK_BASE   = 'h10,
   parameter int DIGEST_BASE  = 'h20,
   parameter int POLL_DELAY   = 2,
   parameter int TIMEOUT      = 1023
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           mode,
   input  logic [NUM_WORDS*DATA_W-1:0]    block_in,
   output logic                           busy,
   output logic [DIGEST_WORDS*DATA_W-1:0] digest_out,
   output logic                           digest_valid,
   input  logic                           digest_ready,
   output logic [1:0]                     err,
   ravan_sha_block_sequencer_if.master    bus
);

   localparam int BW  = NUM_WORDS * DATA_W;
   localparam int GW  = DIGEST_WORDS * DATA_W;
   localparam int MW  = (NUM_WORDS > DIGEST_WORDS) ?
                        NUM_WORDS : DIGEST_WORDS;
   localparam int CW  = (MW > 1) ? $clog2(MW) : 1;
   localparam int PW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int DLW = (POLL_DELAY > 1) ? $clog2(POLL_DELAY) : 1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_CMD,
      S_WAIT,
      S_POLL_REQ,
      S_POLL_CAP,
      S_RD_REQ,
      S_RD_CAP,
      S_OUT
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   poll_q, poll_d;
   logic [DLW-1:0]  dly_q, dly_d;
   logic            mode_q, mode_d;
   logic [BW-1:0]   blk_q, blk_d;
   logic [GW-1:0]   dig_q, dig_d;
   logic [1:0]      err_q, err_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         poll_q  <= '0;
         dly_q   <= '0;
         mode_q  <= 1'b0;
         blk_q   <= '0;
         dig_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         poll_q  <= poll_d;
         dly_q   <= dly_d;
         mode_q  <= mode_d;
         blk_q   <= blk_d;
         dig_q   <= dig_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      poll_d  = poll_q;
      dly_d   = dly_q;
      mode_d  = mode_q;
      blk_d   = blk_q;
      dig_d   = dig_q;
      err_d   = err_q;
      if (bus.cs && bus.core_error)
         err_d[1] = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               blk_d   = block_in;
               mode_d  = mode;
               cnt_d   = '0;
               poll_d  = '0;
               err_d   = '0;
            end
         end
         // block is shifted so the current word is always at the top
         S_LOAD: begin
            blk_d = blk_q << DATA_W;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(NUM_WORDS - 1))
               state_d = S_CMD;
         end
         S_CMD: begin
            dly_d   = '0;
            state_d = (POLL_DELAY == 0) ? S_POLL_REQ : S_WAIT;
         end
         S_WAIT: begin
            dly_d = dly_q + 1'b1;
            if (dly_q == DLW'(POLL_DELAY - 1))
               state_d = S_POLL_REQ;
         end
         S_POLL_REQ: state_d = S_POLL_CAP;
         S_POLL_CAP: begin
            if (bus.read_data[0]) begin
               cnt_d   = '0;
               state_d = S_RD_REQ;
            end else if (poll_q == PW'(TIMEOUT - 1)) begin
               err_d[0] = 1'b1;
               state_d  = S_IDLE;
            end else begin
               poll_d  = poll_q + 1'b1;
               state_d = S_POLL_REQ;
            end
         end
         S_RD_REQ: state_d = S_RD_CAP;
         S_RD_CAP: begin
            dig_d = (dig_q << DATA_W) | GW'(bus.read_data);
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(DIGEST_WORDS - 1))
               state_d = S_OUT;
            else
               state_d = S_RD_REQ;
         end
         S_OUT: begin
            if (digest_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.cs         = 1'b0;
      bus.we         = 1'b0;
      bus.address    = '0;
      bus.write_data = '0;
      unique case (state_q)
         S_LOAD: begin
            bus.cs         = 1'b1;
            bus.we         = 1'b1;
            bus.address    = ADDR_W'(BLOCK_BASE) + ADDR_W'(cnt_q);
            bus.write_data = blk_q[BW-1 -: DATA_W];
         end
         S_CMD: begin
            bus.cs         = 1'b1;
            bus.we         = 1'b1;
            bus.address    = ADDR_W'(CTRL_ADDR);
            bus.write_data = mode_q ? DATA_W'(2) : DATA_W'(1);
         end
         S_POLL_REQ, S_POLL_CAP: begin
            bus.cs      = 1'b1;
            bus.address = ADDR_W'(STATUS_ADDR);
         end
         S_RD_REQ, S_RD_CAP: begin
            bus.cs      = 1'b1;
            bus.address = ADDR_W'(DIGEST_BASE) + ADDR_W'(cnt_q);
         end
         default: ;
      endcase
   end

   assign busy         = (state_q != S_IDLE);
   assign digest_valid = (state_q == S_OUT);
   assign digest_out   = dig_q;
   assign err          = err_q;

endmodule

// File: tb/tb_ravan_sha_block_sequencer.sv
// Bench for the SHA block sequencer: behavioural SHA-256 core on the
// bus, golden vectors, corner-case sequences and randomized blocks.
module tb_ravan_sha_block_sequencer;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [255:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [511:0] ABC_BLK = {
      32'h61626380, {14{32'h0}}, 32'h00000018
   };
   localparam logic [255:0] ABC_DIG = {
      32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
      32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
   };
   localparam logic [511:0] NIST_B1 = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
   };
   localparam logic [511:0] NIST_B2 = {
      {15{32'h0}}, 32'h000001c0
   };
   localparam logic [255:0] NIST_DIG = {
      32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
      32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1
   };

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         mode;
   logic [511:0] block_in;
   logic         busy;
   logic [255:0] digest_out;
   logic         digest_valid;
   logic         digest_ready;
   logic [1:0]   err;

   ravan_sha_block_sequencer_if #(.DATA_W(32), .ADDR_W(8)) bus ();

   ravan_sha_block_sequencer #(.TIMEOUT(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .mode         (mode),
      .block_in     (block_in),
      .busy         (busy),
      .digest_out   (digest_out),
      .digest_valid (digest_valid),
      .digest_ready (digest_ready),
      .err          (err),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;

   function automatic logic [31:0] ror(input logic [31:0] x,
                                       input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_compress(
      input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      for (int i = 0; i < 16; i++)
         w[i] = blk[511-32*i -: 32];
      for (int i = 16; i < 64; i++)
         w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10))
              + w[i-7]
              + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3))
              + w[i-16];
      {a, b, c, d, e, f, g, h} = hin;
      for (int i = 0; i < 64; i++) begin
         t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25))
                + ((e & f) ^ (~e & g)) + K[i] + w[i];
         t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22))
                + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1;
         d = c; c = b; b = a; a = t1 + t2;
      end
      return {a + hin[255:224], b + hin[223:192],
              c + hin[191:160], d + hin[159:128],
              e + hin[127:96],  f + hin[95:64],
              g + hin[63:32],   h + hin[31:0]};
   endfunction

   // behavioural core: registered reads, ready after need_p polls
   logic [511:0] core_blk = '0;
   logic [255:0] core_h   = '0;
   int           rd_cnt   = 0;
   int           stat_rd  = 0;
   int           need_p   = 1;
   logic [39:0]  wr_q [$];
   logic         inj_on   = 1'b0;
   logic [7:0]   inj_addr = 8'h00;

   assign bus.core_error = inj_on && bus.cs && bus.we &&
                           (bus.address == inj_addr);

   always @(posedge clk) begin
      if (bus.cs && bus.we) begin
         wr_q.push_back({bus.address, bus.write_data});
         if (bus.address[7:4] == 4'h1)
            core_blk[511-32*int'(bus.address[3:0]) -: 32]
               <= bus.write_data;
         else if (bus.address == 8'h08) begin
            core_h <= sha_compress(bus.write_data[0] ? IV : core_h,
                                   core_blk);
            rd_cnt <= 0;
         end
      end
      if (bus.cs && !bus.we) begin
         if (bus.address == 8'h09) begin
            rd_cnt  <= rd_cnt + 1;
            stat_rd <= stat_rd + 1;
            bus.read_data <= {31'b0, (rd_cnt + 1 >= 2*need_p - 1)};
         end else if (bus.address[7:3] == 5'b00100)
            bus.read_data <= core_h[255-32*int'(bus.address[2:0]) -: 32];
         else
            bus.read_data <= '0;
      end
   end

   task automatic chk(input string name, input logic [511:0] got,
                      input logic [511:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic wait_valid(input int exp_lat);
      int lat;
      lat = 0;
      while (!digest_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, exp_lat);
   endtask

   task automatic handshake();
      @(negedge clk);
      digest_ready = 1'b1;
      @(posedge clk); #1;
      digest_ready = 1'b0;
      chk("valid_drop", digest_valid, 1'b0);
      chk("busy_drop", busy, 1'b0);
   endtask

   task automatic check_trace(input int base, input logic [511:0] blk,
                              input bit md);
      logic [39:0] e;
      chk("trace_len", wr_q.size() - base, 17);
      for (int k = 0; k < 17 && base + k < wr_q.size(); k++) begin
         if (k < 16)
            e = {8'(8'h10 + k), blk[511-32*k -: 32]};
         else
            e = {8'h08, md ? 32'd2 : 32'd1};
         chk($sformatf("trace%0d", k), wr_q[base+k], e);
      end
   endtask

   task automatic accept(input logic [511:0] blk, input bit md,
                         input int p, output int base);
      need_p = p;
      @(negedge clk);
      block_in = blk;
      mode     = md;
      start    = 1'b1;
      base     = wr_q.size();
      @(posedge clk); #1;
      start    = 1'b0;
      block_in = '0;
      chk("busy_on_accept", busy, 1'b1);
      chk("err_cleared", err, 2'b00);
   endtask

   task automatic run_block(input logic [511:0] blk, input bit md,
                            input int p, input int rdly,
                            output logic [255:0] dig);
      int base;
      accept(blk, md, p, base);
      wait_valid(35 + 2*p);
      dig = digest_out;
      repeat (rdly) begin
         @(posedge clk); #1;
         chk("hold", digest_out, dig);
      end
      handshake();
      check_trace(base, blk, md);
   endtask

   typedef struct {
      logic [511:0] blk;
      bit           md;
      int           p;
      int           rdly;
      bit           chk_dig;
      logic [255:0] exp_dig;
   } vec_t;

   vec_t vt [4];

   initial begin
      logic [255:0] got, d0, model_h, exp_h;
      logic [511:0] rb;
      int           base, n, s0;
      bit           md, saw;

      vt[0] = '{ABC_BLK, 1'b0, 1, 0, 1'b1, ABC_DIG};
      vt[1] = '{NIST_B1, 1'b0, 2, 2, 1'b0, '0};
      vt[2] = '{NIST_B2, 1'b1, 1, 1, 1'b1, NIST_DIG};
      vt[3] = '{ABC_BLK, 1'b0, 4, 3, 1'b1, ABC_DIG};

      rst = 1'b1; start = 1'b0; mode = 1'b0;
      block_in = '0; digest_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs", bus.cs, 1'b0);
      chk("rst_we", bus.we, 1'b0);
      chk("rst_addr", bus.address, 8'h00);
      chk("rst_wdata", bus.write_data, 32'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_valid", digest_valid, 1'b0);
      chk("rst_digest", digest_out, 256'h0);
      chk("rst_err", err, 2'b00);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         run_block(vt[i].blk, vt[i].md, vt[i].p, vt[i].rdly, got);
         if (vt[i].chk_dig)
            chk($sformatf("vec%0d_digest", i), got, vt[i].exp_dig);
         chk($sformatf("vec%0d_err", i), err, 2'b00);
      end

      // back-pressure, ignored starts, start during handshake
      accept(ABC_BLK, 1'b0, 2, base);
      wait_valid(39);
      d0 = digest_out;
      chk("bp_digest", d0, ABC_DIG);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         start    = i[0];
         block_in = {16{$urandom()}};
         @(posedge clk); #1;
         chk("bp_hold", digest_out, d0);
         chk("bp_cs", bus.cs, 1'b0);
         chk("bp_valid", digest_valid, 1'b1);
      end
      @(negedge clk);
      start = 1'b1; block_in = NIST_B1; mode = 1'b0;
      digest_ready = 1'b1;
      base = wr_q.size();
      @(posedge clk); #1;
      digest_ready = 1'b0;
      chk("hs_valid_drop", digest_valid, 1'b0);
      chk("hs_no_accept", busy, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      chk("hs_next_accept", busy, 1'b1);
      wait_valid(39);
      handshake();
      check_trace(base, NIST_B1, 1'b0);

      // timeout with status stuck low
      need_p = 1000;
      s0 = stat_rd;
      @(negedge clk);
      start = 1'b1; block_in = ABC_BLK; mode = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      saw = 1'b0; n = 0;
      while (busy && n < 300) begin
         @(posedge clk); #1;
         n++;
         if (digest_valid) saw = 1'b1;
      end
      chk("to_status_reads", stat_rd - s0, 16);
      chk("to_err", err, 2'b01);
      chk("to_busy", busy, 1'b0);
      chk("to_no_valid", saw, 1'b0);
      run_block(ABC_BLK, 1'b0, 1, 0, got);
      chk("after_to_digest", got, ABC_DIG);

      // reset while loading word 5
      accept(ABC_BLK, 1'b0, 1, base);
      n = 0;
      while (!(bus.cs && bus.we && bus.address == 8'h15) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("mid_load_addr", bus.address, 8'h15);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_cs", bus.cs, 1'b0);
      chk("mid_rst_we", bus.we, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_valid", digest_valid, 1'b0);
      @(posedge clk); #1;
      chk("mid_rst_idle_cs", bus.cs, 1'b0);
      run_block(ABC_BLK, 1'b0, 1, 0, got);
      chk("after_rst_digest", got, ABC_DIG);

      // core error during one load write
      inj_addr = 8'h13;
      inj_on   = 1'b1;
      run_block(ABC_BLK, 1'b0, 2, 1, got);
      inj_on   = 1'b0;
      chk("cerr_err", err, 2'b10);
      chk("cerr_digest", got, ABC_DIG);

      // randomized blocks and chaining against the reference
      model_h = IV;
      for (int i = 0; i < 12; i++) begin
         for (int w = 0; w < 16; w++)
            rb[511-32*w -: 32] = $urandom();
         md = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         exp_h = sha_compress(md ? model_h : IV, rb);
         model_h = exp_h;
         run_block(rb, md, $urandom_range(1, 6),
                   $urandom_range(0, 4), got);
         chk($sformatf("rand%0d_digest", i), got, exp_h);
         chk($sformatf("rand%0d_err", i), err, 2'b00);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               nchk, nerr);
      $finish;
   end

endmodule

// File: doc/ravan_sha_block_sequencer.md
Name: ravan_sha_block_sequencer

Overview:
- Parametrised host-side sequencer that drives the SHA-256 core's register bus.
- On a start handshake it:
  - loads one NUM_WORDS-word message block into the core;
  - issues an init or next command;
  - polls the core's status register until ready;
  - reads back DIGEST_WORDS digest words.
- Presents the assembled digest on a valid/ready output.
- Sits between the RAVAN key/message path and the sha256 instance. Adds mode selection, multi-block chaining, status polling, back-pressure and timeout detection.

Parameters:
DATA_W, 32, core bus data width
ADDR_W, 8, core bus address width
NUM_WORDS, 16, words per message block
DIGEST_WORDS, 8, words read back as digest
CTRL_ADDR, 8'h08, core control register (bit0 init, bit1 next)
STATUS_ADDR, 8'h09, core status register (bit0 ready)
BLOCK_BASE, 8'h10, address of block word 0
DIGEST_BASE, 8'h20, address of digest word 0
POLL_DELAY, 2, idle cycles after command before first status poll
TIMEOUT, 1023, maximum status polls before abort

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, synchronous and active-high
start  in  1  request; accepted only when busy=0
mode  in  1  0=init (first block), 1=next (chained block)
block_in  in  NUM_WORDS*DATA_W  message block; word 0 = MSBs; sampled on accept
busy  out  1  high from accept until digest handed off or abort
digest_out  out  DIGEST_WORDS*DATA_W  digest; word 0 = MSBs
digest_valid  out  1  digest_out valid
digest_ready  in  1  consumer accepts digest
err  out  2  sticky: bit0 timeout, bit1 core error seen
cs  out  1  core chip select
we  out  1  core write enable
address  out  ADDR_W  core register address
write_data  out  DATA_W  core write data
read_data  in  DATA_W  core read data
core_error  in  1  core error flag

Behaviour:
- Reset values:
  - cs, we, busy and digest_valid are 0.
  - address, write_data, digest_out and err are 0.
  - Internal state: IDLE, word counter 0, poll counter 0.
- Reset mid-operation returns to IDLE next cycle. No further bus accesses are made.
- IDLE:
  - start && !busy captures block_in and mode.
  - Clears err and the word counter, sets busy. Next state LOAD.
- LOAD, one word per cycle:
  - cs=1, we=1, address=BLOCK_BASE+k, write_data=word k.
  - After word NUM_WORDS-1, go to CMD.
- CMD, 1 cycle:
  - cs=1, we=1, address=CTRL_ADDR.
  - write_data = 1 if mode=0, else 2.
  - Then WAIT for POLL_DELAY cycles with cs=0.
- POLL_REQ, then POLL_CAP:
  - Both cycles drive cs=1, we=0, address=STATUS_ADDR. Data is captured in POLL_CAP.
  - If read_data[0]=1, clear the word counter and go to RD_REQ.
  - Otherwise increment the poll counter and return to POLL_REQ.
  - When the poll counter reaches TIMEOUT: set err[0], drop busy, go to IDLE. digest_valid is not raised.
- RD_REQ, then RD_CAP:
  - Both cycles drive cs=1, we=0, address=DIGEST_BASE+k.
  - RD_CAP stores read_data into digest word k.
  - After word DIGEST_WORDS-1, go to OUT.
- OUT:
  - cs=0, digest_valid=1. digest_out is held stable while digest_ready=0.
  - When digest_valid && digest_ready: digest_valid=0 and busy=0 on the next cycle, state IDLE.
  - A start asserted in that same cycle is not accepted; it is accepted on the following cycle.
- err[1] is set whenever core_error=1 while cs=1. The sequence still completes.
- Address arithmetic is modulo 2^ADDR_W. The word counter is width clog2(max(NUM_WORDS, DIGEST_WORDS)).
- cs=0 in IDLE, WAIT and OUT. we=0 except in LOAD and CMD.
- Latency from accept to digest_valid, with ready seen on poll p (p≥1):
  - NUM_WORDS + 1 + POLL_DELAY + 2p + 2·DIGEST_WORDS cycles.
  - Default with p=1: 16+1+2+2+16 = 37.
- start while busy=1 is ignored. No queueing.

Test Plan:
- Single block "abc": block_in = 0x61626380, fourteen zero words, 0x00000018; mode=0.
  - Required: digest_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
  - digest_valid at cycle 37 + 2(p-1); err=0.
  - Bus trace: 16 writes at 0x10-0x1F, then write 0x01 to 0x08.
- Two-block chaining: NIST 448-bit message, block 1 with mode=0, then block 2 with mode=1.
  - Required: second command write_data=0x02.
  - Final digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Back-pressure: hold digest_ready=0 for 20 cycles after digest_valid.
  - Required: digest_out stable; no cs activity; start pulses ignored.
  - Release: one-cycle handshake, then busy=0 next cycle.
- Timeout: stub core with status bit0 stuck 0, TIMEOUT=8.
  - Required: exactly 8 poll pairs, then err=2'b01, busy=0, digest_valid never 1.
  - Next start clears err.
- Reset mid-LOAD: assert rst for 1 cycle at word 5.
  - Required: the next cycle has cs=0, we=0, busy=0, digest_valid=0.
  - A subsequent start restarts from address 0x10.
- Core error: core_error=1 during one LOAD write.
  - Required: err[1]=1 sticky; the sequence still delivers digest_valid.
